// File: rtl/contador_pkg.sv
// rtl/contador_pkg.sv - shared defaults and reset-table helper for the sequence counter
package contador_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int DEFAULT_DEPTH = 8;

    // Reset contents of table entry idx: identity sequence 0..DEPTH-1
    function automatic int unsigned init_entry(input int unsigned idx);
        return idx;
    endfunction

endpackage

// File: rtl/buscador_secuencia.sv
// rtl/buscador_secuencia.sv - parallel search of q in the active table and next-value selection
module buscador_secuencia
    import contador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic [WIDTH-1:0]             q_i,
    input  logic [DEPTH-1:0][WIDTH-1:0]  tbl_i,
    input  logic [LW-1:0]                len_i,
    input  logic                         dir_i,
    output logic                         match_o,
    output logic [AW-1:0]                index_o,
    output logic [WIDTH-1:0]             next_o
);

    logic [LW-1:0] last_idx;
    logic [LW-1:0] idx_ext;
    logic [LW-1:0] nxt_idx;

    always_comb begin
        match_o  = 1'b0;
        index_o  = '0;
        last_idx = len_i - LW'(1);
        // Descending scan so the lowest matching index is the one left standing
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if ((LW'(i) < len_i) && (tbl_i[i] == q_i)) begin
                match_o = 1'b1;
                index_o = AW'(i);
            end
        end
        idx_ext = {1'b0, index_o};
        if (!match_o) begin
            nxt_idx = '0;
        end else if (!dir_i) begin
            nxt_idx = (idx_ext == last_idx) ? '0 : idx_ext + LW'(1);
        end else begin
            nxt_idx = (idx_ext == '0) ? last_idx : idx_ext - LW'(1);
        end
        next_o = tbl_i[nxt_idx[AW-1:0]];
    end

endmodule

// File: rtl/contador_secuencia_param.sv
// rtl/contador_secuencia_param.sv - programmable-sequence counter: q, table, length and pulse registers
module contador_secuencia_param
    import contador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [WIDTH-1:0] prog_data,
    input  logic             len_we,
    input  logic [LW-1:0]    len_data,
    output logic [WIDTH-1:0] q,
    output logic             in_seq,
    output logic             wrap,
    output logic             recov
);

    logic [DEPTH-1:0][WIDTH-1:0] tbl_q;
    logic [LW-1:0]               len_q, len_d;
    logic [WIDTH-1:0]            q_q, q_d;
    logic                        wrap_q, wrap_d;
    logic                        recov_q, recov_d;

    logic                        match;
    logic [AW-1:0]               index;
    logic [WIDTH-1:0]            next_val;
    logic                        at_edge;

    buscador_secuencia #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buscador (
        .q_i     (q_q),
        .tbl_i   (tbl_q),
        .len_i   (len_q),
        .dir_i   (dir),
        .match_o (match),
        .index_o (index),
        .next_o  (next_val)
    );

    // A step crosses the wrap boundary when leaving the last entry forward or entry 0 backward
    assign at_edge = dir ? (index == '0) : ({1'b0, index} == (len_q - LW'(1)));

    always_comb begin
        q_d     = q_q;
        wrap_d  = 1'b0;
        recov_d = 1'b0;
        len_d   = len_q;
        if (load) begin
            q_d = load_val;
        end else if (en) begin
            q_d     = next_val;
            wrap_d  = match & at_edge;
            recov_d = ~match;
        end
        if (len_we && (len_data != '0) && (len_data <= LW'(DEPTH))) begin
            len_d = len_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q     <= '0;
            wrap_q  <= 1'b0;
            recov_q <= 1'b0;
            len_q   <= LW'(DEPTH);
        end else begin
            q_q     <= q_d;
            wrap_q  <= wrap_d;
            recov_q <= recov_d;
            len_q   <= len_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= WIDTH'(init_entry(i));
            end
        end else if (prog_we && ({1'b0, prog_addr} < LW'(DEPTH))) begin
            tbl_q[prog_addr] <= prog_data;
        end
    end

    assign q      = q_q;
    assign in_seq = match;
    assign wrap   = wrap_q;
    assign recov  = recov_q;

endmodule

// File: tb/tb_contador_secuencia_param.sv
// tb/tb_contador_secuencia_param.sv - table-driven self-checking bench for contador_secuencia_param
module tb_contador_secuencia_param;

    logic       clk = 1'b0;
    logic       reset, en, dir, load, prog_we, len_we;
    logic [3:0] load_val, prog_data, len_data;
    logic [2:0] prog_addr;
    logic [3:0] q;
    logic       in_seq, wrap, recov;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    contador_secuencia_param #(
        .WIDTH (4),
        .DEPTH (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .dir       (dir),
        .load      (load),
        .load_val  (load_val),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .len_we    (len_we),
        .len_data  (len_data),
        .q         (q),
        .in_seq    (in_seq),
        .wrap      (wrap),
        .recov     (recov)
    );

    typedef struct {
        logic       rst, ld, en, dir;
        logic [3:0] lv;
        logic       pw;
        logic [2:0] pa;
        logic [3:0] pd;
        logic       lw;
        logic [3:0] ll;
        logic [3:0] eq;
        logic       ein, ew, er;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, ld, e, d, input logic [3:0] lv,
                       input logic pw, input logic [2:0] pa, input logic [3:0] pd,
                       input logic lw, input logic [3:0] ll,
                       input logic [3:0] eq, input logic ein, ew, er);
        vec_t v;
        v.rst = rst; v.ld = ld; v.en = e; v.dir = d; v.lv = lv;
        v.pw = pw; v.pa = pa; v.pd = pd; v.lw = lw; v.ll = ll;
        v.eq = eq; v.ein = ein; v.ew = ew; v.er = er;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst; load = v.ld; en = v.en; dir = v.dir; load_val = v.lv;
        prog_we = v.pw; prog_addr = v.pa; prog_data = v.pd;
        len_we = v.lw; len_data = v.ll;
    endtask

    task automatic check(input string name, input logic [3:0] eq, input logic ein, ew, er);
        n_vec++;
        if (q !== eq || in_seq !== ein || wrap !== ew || recov !== er) begin
            n_fail++;
            $display("FAIL %s: got q=%0d in_seq=%b wrap=%b recov=%b, want q=%0d in_seq=%b wrap=%b recov=%b",
                     name, q, in_seq, wrap, recov, eq, ein, ew, er);
        end
    endtask

    initial begin
        vec_t v;
        // rst ld en dir lv  pw pa pd  lw ll  q in w r
        add(1,0,0,0,0,  0,0,0,  0,0,  0,1,0,0);
        for (int k = 1; k <= 9; k++)
            add(0,0,1,0,0, 0,0,0, 0,0, 4'(k % 8),1,(k == 8),0);
        add(0,0,0,0,0,  1,0,3,  0,0,  1,1,0,0);
        add(0,0,0,0,0,  1,1,9,  0,0,  1,0,0,0);
        add(0,0,0,0,0,  1,2,5,  0,0,  1,0,0,0);
        add(0,0,0,0,0,  1,3,12, 1,4,  1,0,0,0);
        add(0,1,0,0,9,  0,0,0,  0,0,  9,1,0,0);
        add(0,0,1,0,0,  0,0,0,  0,0,  5,1,0,0);
        add(0,0,1,0,0,  0,0,0,  0,0,  12,1,0,0);
        add(0,0,1,0,0,  0,0,0,  0,0,  3,1,1,0);
        add(0,1,0,0,7,  0,0,0,  0,0,  7,0,0,0);
        add(0,0,1,1,0,  0,0,0,  0,0,  3,1,0,1);
        add(0,0,1,1,0,  0,0,0,  0,0,  12,1,1,0);
        add(0,0,1,1,0,  0,0,0,  0,0,  5,1,0,0);
        add(0,1,1,0,10, 0,0,0,  0,0,  10,0,0,0);
        add(1,1,0,0,10, 0,0,0,  0,0,  0,1,0,0);
        add(0,1,0,0,6,  0,0,0,  0,0,  6,1,0,0);
        add(0,0,1,0,0,  0,0,0,  1,4,  7,0,0,0);
        add(0,0,1,0,0,  0,0,0,  0,0,  0,1,0,1);
        add(0,0,0,0,0,  0,0,0,  1,0,  0,1,0,0);
        add(0,1,0,0,3,  0,0,0,  1,9,  3,1,0,0);
        add(0,0,1,0,0,  0,0,0,  0,0,  0,1,1,0);
        add(0,0,0,0,0,  0,0,0,  0,0,  0,1,0,0);
        add(0,0,0,0,0,  0,0,0,  1,1,  0,1,0,0);
        add(0,0,1,0,0,  0,0,0,  0,0,  0,1,1,0);
        add(0,0,1,1,0,  0,0,0,  0,0,  0,1,1,0);
        add(0,1,0,0,5,  0,0,0,  0,0,  5,0,0,0);
        add(0,0,1,0,0,  0,0,0,  0,0,  0,1,0,1);
        add(0,0,1,0,0,  1,0,7,  0,0,  0,0,1,0);
        add(0,0,1,0,0,  0,0,0,  0,0,  7,1,0,1);
        add(1,0,1,0,0,  1,0,9,  1,2,  0,1,0,0);
        add(0,0,1,0,0,  0,0,0,  0,0,  1,1,0,0);
        add(0,0,1,0,0,  0,0,0,  0,0,  2,1,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), vecs[i].eq, vecs[i].ein, vecs[i].ew, vecs[i].er);
        end

        // Full backward lap on the identity table after a fresh reset
        v = vecs[0];
        drive(v);
        @(posedge clk);
        #1;
        check("bwd_reset", 4'd0, 1'b1, 1'b0, 1'b0);
        v.rst = 1'b0; v.en = 1'b1; v.dir = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(v);
            @(posedge clk);
            #1;
            check($sformatf("bwd%0d", k), 4'(7 - k), 1'b1, (k == 0), 1'b0);
        end

        // Out-of-range value loaded, held while idle, then recovered to table[0]
        v.en = 1'b0; v.ld = 1'b1; v.lv = 4'd15;
        drive(v);
        @(posedge clk);
        #1;
        check("load15", 4'd15, 1'b0, 1'b0, 1'b0);
        v.ld = 1'b0;
        drive(v);
        @(posedge clk);
        #1;
        check("hold15", 4'd15, 1'b0, 1'b0, 1'b0);
        v.en = 1'b1;
        drive(v);
        @(posedge clk);
        #1;
        check("recov15", 4'd0, 1'b1, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/contador_secuencia_param.md
CONTADOR_SECUENCIA_PARAM -- requirements
Module: contador_secuencia_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning bit width of each counter value.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning maximum sequence length in entries (2..2**WIDTH).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  advance one sequence step this cycle.
REQ-007 dir  input  1  step direction: 0 = forward, 1 = backward.
REQ-008 load  input  1  force q to load_val this cycle.
REQ-009 load_val  input  WIDTH  arbitrary value for load; need not be in sequence.
REQ-010 prog_we  input  1  write one sequence-table entry.
REQ-011 prog_addr  input  clog2(DEPTH)  table index to write.
REQ-012 prog_data  input  WIDTH  value written to table entry.
REQ-013 len_we  input  1  write the active sequence length.
REQ-014 len_data  input  clog2(DEPTH)+1  new active length, 1..DEPTH.
REQ-015 q  output  WIDTH  current counter value, registered.
REQ-016 in_seq  output  1  q matches an entry in table[0..len-1], combinational from registers.
REQ-017 wrap  output  1  one-cycle pulse: last step crossed between entry len-1 and entry 0.
REQ-018 recov  output  1  one-cycle pulse: last step recovered from an out-of-sequence q.

Function
REQ-019 Priority per cycle SHALL be reset > load > en; prog_we and len_we SHALL be independent of these.
REQ-020 Match SHALL be a parallel search of q against table[0..len-1]; on duplicates the lowest index wins.
REQ-021 On en with match at index i and dir=0, q SHALL become table[(i+1) mod len]; with dir=1, table[(i-1) mod len].
REQ-022 On en with no match, q SHALL become table[0] for either dir, and recov SHALL pulse the next cycle.
REQ-023 wrap SHALL pulse on forward step from i=len-1 or backward step from i=0; never together with recov.
REQ-024 With len=1, every en step with a match SHALL leave q=table[0] and pulse wrap.
REQ-025 load SHALL set q=load_val with no recov or wrap pulse; in_seq reflects the loaded value next cycle.
REQ-026 With en=0 and load=0, q SHALL hold; wrap and recov SHALL be 0.
REQ-027 Latency SHALL be one cycle: q, wrap and recov update on the clock edge that samples en or load.
REQ-028 A step and a table or length write in the same cycle SHALL use the old table and length; the new contents apply from the next cycle.
REQ-029 len_data of 0 or greater than DEPTH SHALL be ignored and len SHALL hold.
REQ-030 Shrinking len below the index of the current q SHALL make q out-of-sequence; the next en SHALL recover per REQ-022.
REQ-031 q SHALL never remain outside the sequence for more than one en step.

Reset
REQ-032 On reset, q SHALL be 0, wrap and recov SHALL be 0, and len SHALL be DEPTH.
REQ-033 On reset, table[i] SHALL be i for every i, giving the identity sequence 0..DEPTH-1.
REQ-034 Reset asserted mid-operation SHALL override load, en, prog_we and len_we in that cycle.

Structure
REQ-035 Package contador_pkg SHALL hold default WIDTH and DEPTH, and the reset-table initialisation function.
REQ-036 The search-and-next-value logic SHALL be one sub-module, buscador_secuencia: combinational, outputs match, index and next value.
REQ-037 The top module SHALL hold the q, table, len and pulse registers only.

Verification
REQ-038 Reset, then en=1 and dir=0 for 9 cycles -> q goes 1,2,...,7,0,1; wrap pulses once, after the 7->0 step.
REQ-039 Program table {3,9,5,12} with len=4, load 9, en and dir=0 for 3 cycles -> q goes 5,12,3; wrap follows the 12->3 step.
REQ-040 Same table, load 7, en with dir=1 -> in_seq=0 before the step; q=3 and recov=1 after it; in_seq=1.
REQ-041 Identity table, q=6, write len=4 and en in the same cycle -> q=7, which is out of sequence; the next en gives q=0 and recov=1.
REQ-042 Assert load=1 and en=1 with load_val=10 in the same cycle -> q=10 and no pulses; assert reset together with load -> q=0.
REQ-043 Write len_data=0 -> len unchanged; write len=1 then step -> q stays table[0] and wrap pulses each step.
